extmem_responder: RTL

// Memory-side end of the external-memory interface: answers the controller's we/re/wr_addr/rd_addr/wr_data

---
 rtl/extmem_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/extmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : extmem_responder
// Purpose  : Memory side of the external-memory interface. A single-port SRAM
//            sits behind a posted-write buffer, and a low-priority host port
//            shares the same SRAM.
// Revision : 1.0  initial release
// ============================================================================
module extmem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 65536,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          re,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          host_req,
    input  logic                          host_we,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_wdata,
    output logic                          host_ack,
    output logic [DATA_W-1:0]             host_rdata,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
    output logic                          overflow_err
);

    localparam int                c_ptr_w = $clog2(WBUF_DEPTH);
    localparam int                c_cnt_w = c_ptr_w + 1;
    localparam int                c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(WBUF_DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < c_depth;
    endfunction

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  r_wb_addr [WBUF_DEPTH];
    logic [DATA_W-1:0]  r_wb_data [WBUF_DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic [DATA_W-1:0]  r_rd_data;
    logic               r_host_ack;
    logic [DATA_W-1:0]  r_host_rdata;
    logic               r_overflow;

    logic               w_fwd_hit;
    logic [DATA_W-1:0]  w_fwd_data;
    logic [DATA_W-1:0]  w_rd_word;
    logic               w_wr_ok;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_host_go;
    logic               w_mem_we;
    logic [c_idx_w-1:0] w_mem_idx;
    logic [DATA_W-1:0]  w_mem_wdata;

    // Walk oldest to newest so the last match is the most recent write.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if ((c_cnt_w'(i) < r_count) &&
                (r_wb_addr[r_head + c_ptr_w'(i)] == rd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_wb_data[r_head + c_ptr_w'(i)];
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (in_range(rd_addr)) begin
            w_rd_word = w_fwd_hit ? w_fwd_data : mem[rd_addr[c_idx_w-1:0]];
        end
    end

    assign w_wr_ok   = we && in_range(wr_addr);
    assign w_pop     = !re && (r_count != '0);
    assign w_push    = w_wr_ok && (re ? (r_count != c_full) : (r_count != '0));
    assign w_drop    = re && w_wr_ok && (r_count == c_full);
    assign w_host_go = host_req && !r_host_ack && !re && !we && (r_count == '0);

    // Single SRAM write port: drain, then direct write, then host.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = '0;
        w_mem_wdata = '0;
        if (!re) begin
            if (r_count != '0) begin
                w_mem_we    = 1'b1;
                w_mem_idx   = r_wb_addr[r_head][c_idx_w-1:0];
                w_mem_wdata = r_wb_data[r_head];
            end else if (w_wr_ok) begin
                w_mem_we    = 1'b1;
                w_mem_idx   = wr_addr[c_idx_w-1:0];
                w_mem_wdata = wr_data;
            end else if (w_host_go && host_we && in_range(host_addr)) begin
                w_mem_we    = 1'b1;
                w_mem_idx   = host_addr[c_idx_w-1:0];
                w_mem_wdata = host_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wb_addr[r_tail] <= wr_addr;
            r_wb_data[r_tail] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data    <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_overflow   <= 1'b0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
        end else begin
            r_host_ack <= w_host_go;
            if (re) begin
                r_rd_data <= w_rd_word;
            end
            if (w_host_go && !host_we) begin
                r_host_rdata <= in_range(host_addr) ? mem[host_addr[c_idx_w-1:0]] : '0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    assign rd_data      = r_rd_data;
    assign host_ack     = r_host_ack;
    assign host_rdata   = r_host_rdata;
    assign wbuf_level   = r_count;
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire
